spi_master_fifo_rd: RTL and testbench
=====================================

Name: spi_master_fifo_rd

Overview:
Read-side consumer of the 8x16 dual-clock byte FIFO, running entirely in the rd_clk domain. It pops bytes from the FIFO read port and serialises them MSB-first as an SPI mode-0 master (CPOL=0, CPHA=0), capturing MISO in parallel. Back-to-back bytes are sent as one burst with cs_n held low while the FIFO stays non-empty. Received bytes are presented as a one-cycle rx_valid pulse for the downstream register/parser stage.

Parameters:
CLK_DIV, 4, sclk half-period in rd_clk cycles; legal range 1..255
DATA_W, 8, frame width; fixed to the FIFO word width

Ports:
rd_clk  in  1  system clock, shared with the FIFO read port
PresetFull  in  1  reset, asynchronous, active-high
enable  in  1  transfer enable, level
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  8  FIFO read data, valid the cycle after an accepted fifo_rd_en
fifo_rd_en  out  1  FIFO pop strobe, one-cycle pulse
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data out
cs_n  out  1  SPI chip select, active low
miso  in  1  SPI data in
rx_data  out  8  last received byte
rx_valid  out  1  one-cycle strobe, rx_data updated
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: PresetFull is asynchronous and active-high, clock is rd_clk. While reset is asserted: cs_n=1, sclk=0, mosi=0, fifo_rd_en=0, rx_valid=0, rx_data=0, busy=0, state=IDLE, divider=0, bit count=0.
- All outputs are registered.
- FSM states: IDLE, POP, LOAD, SHIFT, HOLD.
- IDLE: if enable=1 and fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to POP. Otherwise stay.
- POP: one wait cycle for FIFO read latency, then go to LOAD.
- LOAD: capture fifo_dout into the tx shift register; cs_n=0, sclk=0, mosi=bit7; clear divider and bit count; go to SHIFT.
- SHIFT:
  - The divider counts rd_clk cycles; every CLK_DIV cycles sclk toggles.
  - Rising edge: shift miso into the rx shift register (MSB first).
  - Falling edge: drive the next tx bit onto mosi.
  - After 8 rising and 8 falling edges, go to HOLD. mosi keeps bit0, sclk=0.
- HOLD: wait CLK_DIV cycles (cs_n hold time). On the last HOLD cycle: rx_data <= rx shift register, rx_valid=1 for one cycle. Then:
  - if enable=1 and fifo_empty=0: pulse fifo_rd_en, go to POP with cs_n kept low (burst);
  - otherwise: cs_n=1, mosi=0, go to IDLE.
- Timing: LOAD-to-rx_valid = 1 + 17*CLK_DIV cycles. With CLK_DIV=4, the first sclk rise is 4 cycles after LOAD.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled, and never in POP, LOAD or SHIFT. At most one pop is outstanding.
- enable deasserted mid-byte: the current byte completes, including rx_valid, then the block returns to IDLE with cs_n released.
- fifo_empty going high during a byte has no effect until the HOLD decision point.
- Reset asserted mid-byte: immediate abort, no rx_valid, cs_n=1 asynchronously.
- No state is retained across reset.

Decomposition:
- Package spi_pkg: state enum (IDLE, POP, LOAD, SHIFT, HOLD), DATA_W=8, SPI mode constants.
- Sub-module spi_clk_div: half-period tick generator with a clear input. It emits a one-cycle tick every CLK_DIV cycles; the FSM uses it for both SHIFT and HOLD.

Test Plan:
1. Reset mid-transfer (CLK_DIV=4): assert PresetFull at sclk edge 5 -> cs_n=1, sclk=0, mosi=0 within the same cycle; no rx_valid; fifo_rd_en=0.
2. Single byte (CLK_DIV=2): enable=1, FIFO holds 0xA5, miso loops back mosi.
   - Expect one fifo_rd_en pulse; mosi shows 1,0,1,0,0,1,0,1 at the sclk rises; 8 sclk pulses.
   - Expect rx_data=0xA5 and rx_valid at LOAD+35.
   - Expect cs_n to rise the next cycle.
3. Burst of three bytes (CLK_DIV=1): FIFO holds 0x01, 0x80, 0xFF -> cs_n stays low across all three bytes; exactly 3 fifo_rd_en pulses; rx_valid three times with the looped-back values; then IDLE.
4. Empty FIFO: enable=1, fifo_empty=1 for 100 cycles -> fifo_rd_en, busy and cs_n never change (0, 0, 1).
5. enable drops at sclk edge 3 of byte 0x3C while the FIFO is non-empty -> byte 0x3C completes with rx_valid; no further pop; cs_n=1 after HOLD.
6. MISO capture: miso driven as constant 0x5A pattern (miso changes only on sclk falls) while transmitting 0x00 -> rx_data=0x5A, mosi stays 0 throughout.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the rd_clk-domain SPI master that drains the byte FIFO.
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SHIFT,
        HOLD
    } state_t;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles, restarted by clr.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic rd_clk,
    input  logic PresetFull,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d;
    logic       at_end;

    assign at_end = (cnt_q == 8'(CLK_DIV - 1));
    assign tick   = at_end && !clr;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || at_end) cnt_d = '0;
    end

    always_ff @(posedge rd_clk or posedge PresetFull) begin
        if (PresetFull) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master_fifo_rd.sv
// SPI mode-0 master popping bytes from the FIFO read port; cs_n stays low across
// back-to-back bytes and each received byte is strobed out on rx_valid.
module spi_master_fifo_rd
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              rd_clk,
    input  logic              PresetFull,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);
    localparam int CNT_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              tick, div_clr, can_pop, capture_edge;

    // Divider free-runs only while a byte is on the wire (SHIFT) or in its cs_n hold.
    assign div_clr = (state_q != SHIFT) && (state_q != HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .rd_clk    (rd_clk),
        .PresetFull(PresetFull),
        .clr       (div_clr),
        .tick      (tick)
    );

    assign can_pop      = enable && !fifo_empty;
    assign capture_edge = (sclk_q == SPI_CPOL) ^ SPI_CPHA;

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rd_en_d    = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_pop) begin
                    rd_en_d = 1'b1;
                    state_d = POP;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                tx_sr_d    = fifo_dout;
                cs_n_d     = 1'b0;
                sclk_d     = SPI_CPOL;
                mosi_d     = fifo_dout[DATA_W-1];
                edge_cnt_d = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (capture_edge) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    end else if (edge_cnt_q != LAST_EDGE) begin
                        // Last falling edge leaves bit0 on mosi.
                        tx_sr_d = tx_sr_q << 1;
                        mosi_d  = tx_sr_q[DATA_W-2];
                    end
                    if (edge_cnt_q == LAST_EDGE) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    if (can_pop) begin
                        rd_en_d = 1'b1;
                        state_d = POP;
                    end else begin
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge rd_clk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= SPI_CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_en_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rd_en_q    <= rd_en_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_spi_master_fifo_rd.sv
// Directed bench: three instances (CLK_DIV 4, 2, 1), each fed by its own small FIFO model.
`timescale 1ns/1ps
module tb_spi_master_fifo_rd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en       [3];
    logic       rd_en    [3];
    logic       sclk     [3];
    logic       mosi     [3];
    logic       cs_n     [3];
    logic       miso     [3];
    logic       rx_valid [3];
    logic       busy     [3];
    logic [7:0] rx_data  [3];
    logic [7:0] mem      [3][8];
    logic [2:0] wr_ptr   [3];
    logic       loop1;
    logic [7:0] pat1;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        logic [2:0] rd_ptr = '0;
        logic [7:0] dout   = '0;
        logic       emp;
        assign emp = (wr_ptr[g] == rd_ptr);
        assign miso[g] = (g == 1 && !loop1) ? pat1[7] : mosi[g];
        always @(posedge clk) begin
            if (rd_en[g] && !emp) begin
                dout   <= mem[g][rd_ptr];
                rd_ptr <= rd_ptr + 3'd1;
            end
        end
        spi_master_fifo_rd #(.CLK_DIV(DIV), .DATA_W(8)) u_dut (
            .rd_clk    (clk),
            .PresetFull(rst),
            .enable    (en[g]),
            .fifo_empty(emp),
            .fifo_dout (dout),
            .fifo_rd_en(rd_en[g]),
            .sclk      (sclk[g]),
            .mosi      (mosi[g]),
            .cs_n      (cs_n[g]),
            .miso      (miso[g]),
            .rx_data   (rx_data[g]),
            .rx_valid  (rx_valid[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        logic [7:0] tx;
        logic       loop;
        logic [7:0] pat;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] b);
        mem[g][wr_ptr[g]] = b;
        wr_ptr[g] = wr_ptr[g] + 3'd1;
    endtask

    // One byte on the CLK_DIV=2 instance.
    task automatic run_vec(input int idx, input vec_t v);
        int pops = 0, rises = 0, pop_c = -1, rv_c = -1;
        logic [7:0] mbits = '0, got = '0;
        logic prev = 1'b0, mosi_hi = 1'b0;
        loop1 = v.loop;
        pat1  = v.pat;
        push(1, v.tx);
        en[1] = 1'b1;
        for (int c = 0; c < 300 && rv_c < 0; c++) begin
            @(negedge clk);
            if (rd_en[1]) begin
                pops++;
                if (pop_c < 0) pop_c = c;
            end
            if (sclk[1] && !prev) begin
                rises++;
                mbits = {mbits[6:0], mosi[1]};
            end
            if (!sclk[1] && prev) pat1 = pat1 << 1;
            if (mosi[1]) mosi_hi = 1'b1;
            prev = sclk[1];
            if (rx_valid[1]) begin
                rv_c = c;
                got  = rx_data[1];
            end
        end
        en[1] = 1'b0;
        chk($sformatf("v%0d_pops", idx), pops, 1);
        chk($sformatf("v%0d_sclk_rises", idx), rises, 8);
        chk($sformatf("v%0d_mosi_bits", idx), int'(mbits), int'(v.tx));
        chk($sformatf("v%0d_mosi_any", idx), int'(mosi_hi), int'(|v.tx));
        chk($sformatf("v%0d_rx_data", idx), int'(got), int'(v.exp_rx));
        chk($sformatf("v%0d_pop_to_rx_valid", idx), rv_c - pop_c, v.exp_lat);
        @(negedge clk);
        chk($sformatf("v%0d_cs_n_after", idx), int'(cs_n[1]), 1);
        chk($sformatf("v%0d_busy_after", idx), int'(busy[1]), 0);
        chk($sformatf("v%0d_rx_valid_pulse", idx), int'(rx_valid[1]), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int edges, rv, pops, nrx, breaks, bad_rd, bad_busy, bad_cs;
        logic prev, cs_low_seen;
        logic [7:0] rxs [3];
        int popc [3];
        int rvc  [3];
        logic [7:0] burst_exp [3];

        // POP->LOAD is 1 cycle, LOAD->rx_valid is 1 + 17*2.
        vt[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 36};
        vt[1] = '{8'h00, 1'b0, 8'h5A, 8'h5A, 36};
        vt[2] = '{8'hFF, 1'b0, 8'h00, 8'h00, 36};
        vt[3] = '{8'h81, 1'b0, 8'hC6, 8'hC6, 36};
        vt[4] = '{8'h3C, 1'b1, 8'h00, 8'h3C, 36};
        burst_exp[0] = 8'h01;
        burst_exp[1] = 8'h80;
        burst_exp[2] = 8'hFF;

        rst   = 1'b1;
        loop1 = 1'b1;
        pat1  = 8'h00;
        for (int g = 0; g < 3; g++) begin
            en[g]     = 1'b0;
            wr_ptr[g] = '0;
        end
        #2;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst%0d_cs_n", g), int'(cs_n[g]), 1);
            chk($sformatf("rst%0d_sclk", g), int'(sclk[g]), 0);
            chk($sformatf("rst%0d_mosi", g), int'(mosi[g]), 0);
            chk($sformatf("rst%0d_rd_en", g), int'(rd_en[g]), 0);
            chk($sformatf("rst%0d_rx_valid", g), int'(rx_valid[g]), 0);
            chk($sformatf("rst%0d_rx_data", g), int'(rx_data[g]), 0);
            chk($sformatf("rst%0d_busy", g), int'(busy[g]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset at sclk edge 5 (third rise, mosi=bit5=1) on the CLK_DIV=4 instance.
        push(0, 8'hE7);
        en[0] = 1'b1;
        edges = 0;
        prev  = 1'b0;
        for (int c = 0; c < 200 && edges < 5; c++) begin
            @(negedge clk);
            if (sclk[0] != prev) edges++;
            prev = sclk[0];
        end
        chk("t1_reached_edge5", edges, 5);
        chk("t1_mosi_before_rst", int'(mosi[0]), 1);
        rst = 1'b1;
        #1;
        chk("t1_cs_n_async", int'(cs_n[0]), 1);
        chk("t1_sclk_async", int'(sclk[0]), 0);
        chk("t1_mosi_async", int'(mosi[0]), 0);
        chk("t1_rd_en_async", int'(rd_en[0]), 0);
        chk("t1_busy_async", int'(busy[0]), 0);
        en[0] = 1'b0;
        rv = 0;
        repeat (4) begin
            @(negedge clk);
            if (rx_valid[0]) rv++;
        end
        rst = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (rx_valid[0]) rv++;
        end
        chk("t1_no_rx_valid", rv, 0);
        chk("t1_cs_n_idle", int'(cs_n[0]), 1);

        // Single-byte table on the CLK_DIV=2 instance.
        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);
        loop1 = 1'b1;

        // Enabled with an empty FIFO.
        en[1]    = 1'b1;
        bad_rd   = 0;
        bad_busy = 0;
        bad_cs   = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en[1]) bad_rd++;
            if (busy[1]) bad_busy++;
            if (!cs_n[1]) bad_cs++;
        end
        en[1] = 1'b0;
        chk("t4_rd_en_changes", bad_rd, 0);
        chk("t4_busy_changes", bad_busy, 0);
        chk("t4_cs_n_changes", bad_cs, 0);

        // Three-byte burst on the CLK_DIV=1 instance.
        push(2, 8'h01);
        push(2, 8'h80);
        push(2, 8'hFF);
        en[2]       = 1'b1;
        pops        = 0;
        nrx         = 0;
        breaks      = 0;
        cs_low_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            popc[i] = -1;
            rvc[i]  = -100;
            rxs[i]  = '0;
        end
        for (int c = 0; c < 300 && nrx < 3; c++) begin
            @(negedge clk);
            if (rd_en[2]) begin
                if (pops < 3) popc[pops] = c;
                pops++;
            end
            if (rx_valid[2]) begin
                if (nrx < 3) begin
                    rxs[nrx] = rx_data[2];
                    rvc[nrx] = c;
                end
                nrx++;
            end
            if (cs_low_seen && cs_n[2] && nrx < 3) breaks++;
            if (!cs_n[2]) cs_low_seen = 1'b1;
        end
        en[2] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en[2]) pops++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_rx%0d", i), int'(rxs[i]), int'(burst_exp[i]));
            chk($sformatf("t3_lat%0d", i), rvc[i] - popc[i], 19);
        end
        chk("t3_pops", pops, 3);
        chk("t3_rx_count", nrx, 3);
        chk("t3_cs_n_breaks", breaks, 0);
        chk("t3_cs_n_end", int'(cs_n[2]), 1);
        chk("t3_busy_end", int'(busy[2]), 0);

        // enable dropped at sclk edge 3 of 0x3C with a second byte waiting.
        push(1, 8'h3C);
        push(1, 8'h77);
        en[1] = 1'b1;
        edges = 0;
        prev  = 1'b0;
        pops  = 0;
        rv    = 0;
        rxs[0] = '0;
        for (int c = 0; c < 300 && rv == 0; c++) begin
            @(negedge clk);
            if (rd_en[1]) pops++;
            if (sclk[1] != prev) edges++;
            prev = sclk[1];
            if (edges == 3) en[1] = 1'b0;
            if (rx_valid[1]) begin
                rv++;
                rxs[0] = rx_data[1];
            end
        end
        en[1] = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rd_en[1]) pops++;
            if (rx_valid[1]) rv++;
        end
        chk("t5_rx_data", int'(rxs[0]), 8'h3C);
        chk("t5_rx_valid_count", rv, 1);
        chk("t5_pops", pops, 1);
        chk("t5_cs_n_end", int'(cs_n[1]), 1);
        chk("t5_busy_end", int'(busy[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
